axis_owen_scrambler_nd: RTL and testbench
=========================================

Name: axis_owen_scrambler_nd

Overview:
N-dimensional, backpressure-aware successor of the two-dimensional Laine-Karras Owen scrambler in the low-discrepancy sampling path. It is an AXI-Stream stage between the Sobol point generator and the GGX sampler. Each beat carries DIMS 32-bit fixed-point coordinates. Each coordinate is Owen-scrambled with a per-dimension seed derived from pixel_id and sample_id. New over the previous generation: full tready backpressure, tlast passthrough, parametrised dimension count, and a run-time bypass mode.

Parameters:
DIMS, 2, coordinates per beat; legal range 1..8.
FRAC_BITS, 32, bits per coordinate; fixed at 32 because the hash constants are 32-bit; elaboration error otherwise.
C_S00_AXIS_TDATA_WIDTH, DIMS*FRAC_BITS, input tdata width.
C_M00_AXIS_TDATA_WIDTH, DIMS*FRAC_BITS, output tdata width.

Ports:
s00_axis_aclk  in  1  sole clock.
s00_axis_aresetn  in  1  asynchronous, active-low reset.
s00_axis_tvalid  in  1  input beat valid.
s00_axis_tready  out  1  input beat accepted when tvalid && tready.
s00_axis_tlast  in  1  end of packet; carried through with the beat.
s00_axis_tdata  in  C_S00_AXIS_TDATA_WIDTH  dimension d occupies bits [d*32 +: 32].
s00_axis_tstrb  in  C_S00_AXIS_TDATA_WIDTH/8  ignored.
pixel_id  in  32  seed sideband; sampled on the accepted beat.
sample_id  in  32  seed sideband; sampled on the accepted beat.
bypass  in  1  1 = pass coordinates unscrambled; sampled per accepted beat.
m00_axis_tvalid  out  1  output beat valid.
m00_axis_tready  in  1  downstream ready.
m00_axis_tlast  out  1  tlast of the corresponding input beat.
m00_axis_tdata  out  C_M00_AXIS_TDATA_WIDTH  scrambled coordinates, same lane layout as the input.
m00_axis_tstrb  out  C_M00_AXIS_TDATA_WIDTH/8  constant all-ones.

Behaviour:
- Reset is asynchronous, active-low. On assertion, all stage valids, m00_axis_tvalid, m00_axis_tlast and m00_axis_tdata clear to 0. s00_axis_tready is 0 while reset is asserted.
- Reset mid-operation discards every in-flight beat. No output is produced for those beats.
- Pipeline enable: en = !m00_axis_tvalid || m00_axis_tready. Every stage register (data, valid, tlast, bypass) advances only when en is high.
- s00_axis_tready = en (registered stages, no combinational path from tdata).
- When en is low, all stages hold. The output beat stays stable until it is accepted (AXIS rule).
- Throughput: 1 beat per cycle with m00_axis_tready held high.
- Latency: exactly 7 enabled cycles from input acceptance to m00_axis_tvalid.
- S0 (on accept): rev_d = bitrev32(u_d); P = pixel_id*K_PIXEL; Q = sample_id*K_SAMPLE.
- S1: seed = P ^ Q.
- S2: seed_d = seed ^ (d*K_DIM), with d*K_DIM an elaboration-time constant; x_d = rev_d + seed_d.
- S3..S6: four rounds, x = x ^ (x*H_k) for k = 1..4.
- S7 (output register): out_d = bitrev32(x_d). If the beat's bypass bit is 1, out_d = u_d instead, which requires the original u_d to be piped alongside.
- Arithmetic: all multiplies and adds are 32-bit, truncated modulo 2^32. Products are unsigned.
- Constants:
  - K_PIXEL = 9e3779b1
  - K_SAMPLE = 85ebca6b
  - K_DIM = c2b2ae35
  - H1 = 6c50b47c
  - H2 = b82f1e52
  - H3 = c7afe638
  - H4 = 8d22f6e6
- Input tvalid low: a bubble (valid = 0) enters S0. Bubbles are not compressed, but they are overwritten when the output is free.
- Simultaneous output accept and input accept in the same cycle is legal and sustains full rate.
- tlast and bypass are never altered, only delayed with their beat.

Decomposition:
- Package owen_pkg holds:
  - K_PIXEL, K_SAMPLE, K_DIM, H1..H4 as 32-bit localparams;
  - function bitrev32;
  - LK_LATENCY = 7.
- Sub-module owen_lane (parameter DIM_INDEX): the per-dimension S2..S7 datapath, with inputs en, rev, u, seed, bypass. It is instantiated DIMS times by generate.
- The top level owns the shared seed stages S0..S1, the valid/tlast/bypass shift chain, and the handshake.

Test Plan:
- Reset, then bypass=0, pixel_id=0, sample_id=0, all u_d=0, tready=1 -> one beat after 7 cycles; lane0 = 00000000; lane1 equals the golden model (seed c2b2ae35); tlast echoed.
- bypass=1, DIMS=4, lanes 11111111/22222222/80000001/ffffffff -> output lanes bit-identical after 7 cycles; tstrb = ffff.
- 64 back-to-back beats with random u, pixel_id and sample_id, tready=1 -> 64 outputs in order, one per cycle, all matching the golden model; s00_axis_tready constantly 1.
- Random m00_axis_tready (50% duty) over 200 beats -> no loss or duplication; tdata and tlast stable while tvalid && !tready; tready deasserts exactly when the output is stalled.
- tlast=1 on beats 3 and 7 of 8, with bypass toggling per beat -> tlast and the bypass effect appear on the matching output beats only.
- aresetn asserted asynchronously mid-burst with 5 beats in flight -> m00_axis_tvalid falls immediately; after release no stale beats appear; the next input emerges 7 cycles after acceptance.

Source files
------------

// File: rtl/owen_pkg.sv
// Shared constants and helpers for the N-dimensional Owen scrambler.
//   K_PIXEL / K_SAMPLE : seed hashing multipliers for pixel_id / sample_id
//   K_DIM              : per-dimension seed decorrelation multiplier
//   H1..H4             : Laine-Karras style mixing round multipliers
//   LK_LATENCY         : enabled cycles from input acceptance to output valid
//   bitrev32           : 32-bit bit reversal
package owen_pkg;

  localparam logic [31:0] K_PIXEL  = 32'h9e3779b1;
  localparam logic [31:0] K_SAMPLE = 32'h85ebca6b;
  localparam logic [31:0] K_DIM    = 32'hc2b2ae35;
  localparam logic [31:0] H1       = 32'h6c50b47c;
  localparam logic [31:0] H2       = 32'hb82f1e52;
  localparam logic [31:0] H3       = 32'hc7afe638;
  localparam logic [31:0] H4       = 32'h8d22f6e6;

  localparam int LK_LATENCY = 7;

  function automatic logic [31:0] bitrev32(input logic [31:0] v);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      r[i] = v[31-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/axis_owen_scrambler_nd_lane.sv
// Per-dimension Owen scrambling datapath, stages S2..S7.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (output register only)
//   en         : pipeline enable shared with the top-level handshake
//   rev        : bit-reversed coordinate from S1
//   u          : original coordinate from S1 (needed for bypass)
//   seed       : shared pixel/sample seed from S1
//   bypass     : beat bypass flag from S1
//   out        : scrambled (or bypassed) coordinate, registered in S7
module owen_lane
  import owen_pkg::*;
#(
  parameter int DIM_INDEX = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [31:0] rev,
  input  logic [31:0] u,
  input  logic [31:0] seed,
  input  logic        bypass,
  output logic [31:0] out
);

  // Constant per-dimension seed offset, folded at elaboration.
  localparam logic [31:0] DIM_SEED = 32'(32'(DIM_INDEX) * K_DIM);

  function automatic logic [31:0] mix_round(input logic [31:0] x, input logic [31:0] h);
    logic [31:0] prod;
    prod = x * h;
    return x ^ prod;
  endfunction

  logic [31:0] x_p2, x_p3, x_p4, x_p5, x_p6;
  logic [31:0] u_p2, u_p3, u_p4, u_p5, u_p6;
  logic        byp_p2, byp_p3, byp_p4, byp_p5, byp_p6;

  always_ff @(posedge clk) begin
    if (en) begin
      // S2: per-dimension seed applied to the reversed coordinate
      x_p2   <= rev + (seed ^ DIM_SEED);
      u_p2   <= u;
      byp_p2 <= bypass;
      // S3..S6: four mixing rounds
      x_p3   <= mix_round(x_p2, H1);
      u_p3   <= u_p2;
      byp_p3 <= byp_p2;
      x_p4   <= mix_round(x_p3, H2);
      u_p4   <= u_p3;
      byp_p4 <= byp_p3;
      x_p5   <= mix_round(x_p4, H3);
      u_p5   <= u_p4;
      byp_p5 <= byp_p4;
      x_p6   <= mix_round(x_p5, H4);
      u_p6   <= u_p5;
      byp_p6 <= byp_p5;
    end
  end

  // S7: output register, cleared on reset so m00_axis_tdata reads zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out <= '0;
    end else if (en) begin
      out <= byp_p6 ? u_p6 : bitrev32(x_p6);
    end
  end

endmodule

// File: rtl/axis_owen_scrambler_nd.sv
// AXI-Stream N-dimensional Owen scrambler (Sobol generator -> GGX sampler).
// Each beat carries DIMS 32-bit coordinates; each is scrambled with a seed
// derived from pixel_id/sample_id and its dimension index, unless bypass.
// Ports:
//   s00_axis_aclk / s00_axis_aresetn : clock, asynchronous active-low reset
//   s00_axis_* : input stream (tstrb ignored), tready = pipeline enable
//   pixel_id, sample_id, bypass : sideband sampled with the accepted beat
//   m00_axis_* : output stream, tstrb constant all-ones
// Latency is LK_LATENCY enabled cycles; the whole pipeline stalls together.
module axis_owen_scrambler_nd
  import owen_pkg::*;
#(
  parameter int DIMS                   = 2,
  parameter int FRAC_BITS              = 32,
  parameter int C_S00_AXIS_TDATA_WIDTH = DIMS * FRAC_BITS,
  parameter int C_M00_AXIS_TDATA_WIDTH = DIMS * FRAC_BITS
) (
  input  logic                                  s00_axis_aclk,
  input  logic                                  s00_axis_aresetn,
  input  logic                                  s00_axis_tvalid,
  output logic                                  s00_axis_tready,
  input  logic                                  s00_axis_tlast,
  input  logic [C_S00_AXIS_TDATA_WIDTH-1:0]     s00_axis_tdata,
  input  logic [C_S00_AXIS_TDATA_WIDTH/8-1:0]   s00_axis_tstrb,
  input  logic [31:0]                           pixel_id,
  input  logic [31:0]                           sample_id,
  input  logic                                  bypass,
  output logic                                  m00_axis_tvalid,
  input  logic                                  m00_axis_tready,
  output logic                                  m00_axis_tlast,
  output logic [C_M00_AXIS_TDATA_WIDTH-1:0]     m00_axis_tdata,
  output logic [C_M00_AXIS_TDATA_WIDTH/8-1:0]   m00_axis_tstrb
);

  if (FRAC_BITS != 32) begin : g_bad_frac_bits
    $error("axis_owen_scrambler_nd: FRAC_BITS must be 32");
  end
  if (DIMS < 1 || DIMS > 8) begin : g_bad_dims
    $error("axis_owen_scrambler_nd: DIMS must be in 1..8");
  end

  logic en;
  logic unused_tstrb;

  logic [DIMS-1:0][31:0] rev_p0, u_p0, rev_p1, u_p1;
  logic [31:0]           p_p0, q_p0, seed_p1;
  logic                  byp_p0, byp_p1;

  // Bit k of each chain tracks stage Sk; bit LK_LATENCY is the output register.
  logic [LK_LATENCY:0]   vld_pipe, last_pipe;
  logic [DIMS-1:0][31:0] lane_out;

  assign en              = !m00_axis_tvalid || m00_axis_tready;
  assign s00_axis_tready = en && s00_axis_aresetn;
  assign unused_tstrb    = ^s00_axis_tstrb;

  always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
    if (!s00_axis_aresetn) begin
      vld_pipe  <= '0;
      last_pipe <= '0;
    end else if (en) begin
      vld_pipe  <= {vld_pipe[LK_LATENCY-1:0], s00_axis_tvalid};
      last_pipe <= {last_pipe[LK_LATENCY-1:0], s00_axis_tvalid && s00_axis_tlast};
    end
  end

  always_ff @(posedge s00_axis_aclk) begin
    if (en) begin
      // S0: capture beat, reverse coordinates, hash sideband ids
      for (int d = 0; d < DIMS; d++) begin
        u_p0[d]   <= s00_axis_tdata[d*FRAC_BITS +: 32];
        rev_p0[d] <= bitrev32(s00_axis_tdata[d*FRAC_BITS +: 32]);
      end
      p_p0    <= pixel_id * K_PIXEL;
      q_p0    <= sample_id * K_SAMPLE;
      byp_p0  <= bypass;
      // S1: combine into the shared seed
      seed_p1 <= p_p0 ^ q_p0;
      rev_p1  <= rev_p0;
      u_p1    <= u_p0;
      byp_p1  <= byp_p0;
    end
  end

  for (genvar g = 0; g < DIMS; g++) begin : g_lane
    owen_lane #(
      .DIM_INDEX(g)
    ) u_lane (
      .clk    (s00_axis_aclk),
      .rst_n  (s00_axis_aresetn),
      .en     (en),
      .rev    (rev_p1[g]),
      .u      (u_p1[g]),
      .seed   (seed_p1),
      .bypass (byp_p1),
      .out    (lane_out[g])
    );
  end

  assign m00_axis_tvalid = vld_pipe[LK_LATENCY];
  assign m00_axis_tlast  = last_pipe[LK_LATENCY];
  assign m00_axis_tdata  = lane_out;
  assign m00_axis_tstrb  = '1;

endmodule

// File: tb/tb_axis_owen_scrambler_nd.sv
module tb_axis_owen_scrambler_nd;

  localparam int DIMS = 4;
  localparam int W    = DIMS * 32;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           s_tvalid, s_tready, s_tlast;
  logic [W-1:0]   s_tdata;
  logic [W/8-1:0] s_tstrb;
  logic [31:0]    pixel_id, sample_id;
  logic           bypass;
  logic           m_tvalid, m_tready, m_tlast;
  logic [W-1:0]   m_tdata;
  logic [W/8-1:0] m_tstrb;

  always #5 clk = ~clk;

  axis_owen_scrambler_nd #(.DIMS(DIMS)) dut (
    .s00_axis_aclk    (clk),
    .s00_axis_aresetn (rst_n),
    .s00_axis_tvalid  (s_tvalid),
    .s00_axis_tready  (s_tready),
    .s00_axis_tlast   (s_tlast),
    .s00_axis_tdata   (s_tdata),
    .s00_axis_tstrb   (s_tstrb),
    .pixel_id         (pixel_id),
    .sample_id        (sample_id),
    .bypass           (bypass),
    .m00_axis_tvalid  (m_tvalid),
    .m00_axis_tready  (m_tready),
    .m00_axis_tlast   (m_tlast),
    .m00_axis_tdata   (m_tdata),
    .m00_axis_tstrb   (m_tstrb)
  );

  typedef struct packed {
    logic [W-1:0] data;
    logic         last;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  logic rnd_en = 1'b0;

  function automatic logic [31:0] brev(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

  function automatic logic [W-1:0] model(input logic [W-1:0] u, input logic [31:0] pix,
                                         input logic [31:0] smp, input logic byp);
    logic [W-1:0] o;
    logic [31:0]  seed, x, ud, a, b;
    a    = pix * 32'h9e3779b1;
    b    = smp * 32'h85ebca6b;
    seed = a ^ b;
    for (int d = 0; d < DIMS; d++) begin
      ud = u[d*32 +: 32];
      a  = 32'(d) * 32'hc2b2ae35;
      x  = brev(ud) + (seed ^ a);
      b  = x * 32'h6c50b47c; x = x ^ b;
      b  = x * 32'hb82f1e52; x = x ^ b;
      b  = x * 32'hc7afe638; x = x ^ b;
      b  = x * 32'h8d22f6e6; x = x ^ b;
      o[d*32 +: 32] = byp ? ud : brev(x);
    end
    return o;
  endfunction

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, req);
    end
  endtask

  // Drive one beat (caller is just after a rising edge); returns just after
  // the accepting edge and records the expected output.
  task automatic send(input logic [W-1:0] u, input logic [31:0] pix, input logic [31:0] smp,
                      input logic byp, input logic last);
    logic acc;
    int   n;
    s_tvalid = 1'b1; s_tdata = u; pixel_id = pix; sample_id = smp;
    bypass = byp; s_tlast = last;
    acc = 1'b0; n = 0;
    while (!acc && n < 1000) begin
      @(negedge clk); acc = s_tready;
      @(posedge clk); #1; n++;
    end
    if (!acc) chk("accept_timeout", 0, 1);
    else exp_q.push_back('{data: model(u, pix, smp, byp), last: last});
  endtask

  task automatic idle();
    s_tvalid = 1'b0; s_tlast = 1'b0;
  endtask

  task automatic latency(input string nm);
    int lat = 0;
    while (!m_tvalid && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    chk(nm, lat, 7);
  endtask

  task automatic drain(input string nm);
    int n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(posedge clk); #1; n++;
    end
    chk(nm, exp_q.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor and AXIS stability checks, on the falling edge.
  logic         held_v = 1'b0;
  logic [W-1:0] held_d;
  logic         held_l;
  always @(negedge clk) begin
    if (!rst_n) begin
      held_v = 1'b0;
    end else begin
      if (held_v) begin
        chk("hold_valid", m_tvalid, 1);
        chk("hold_data", m_tdata, held_d);
        chk("hold_last", m_tlast, held_l);
      end
      chk("s_tready", s_tready, !m_tvalid || m_tready);
      if (m_tvalid && m_tready) begin
        if (exp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_beat: got %h expected none", m_tdata);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("out_data", m_tdata, e.data);
          chk("out_last", m_tlast, e.last);
          chk("out_strb", m_tstrb, {(W/8){1'b1}});
        end
      end
      held_v = m_tvalid && !m_tready;
      held_d = m_tdata;
      held_l = m_tlast;
    end
  end

  always @(posedge clk) begin
    #1;
    if (rnd_en) m_tready = 1'($urandom_range(0, 1));
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] pat;
    rst_n = 1'b0; s_tvalid = 1'b0; s_tlast = 1'b0; s_tdata = '0; s_tstrb = '0;
    pixel_id = '0; sample_id = '0; bypass = 1'b0; m_tready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tvalid", m_tvalid, 0);
    chk("rst_tlast", m_tlast, 0);
    chk("rst_tdata", m_tdata, 0);
    chk("rst_s_tready", s_tready, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // All-zero beat: lane0 is zero, other lanes carry the dimension seed.
    send('0, 32'd0, 32'd0, 1'b0, 1'b1);
    idle();
    latency("latency_zero");
    chk("zero_lane0", m_tdata[31:0], 32'h0000_0000);
    drain("drain_zero");

    // Bypass returns coordinates unchanged.
    send({32'hffffffff, 32'h80000001, 32'h22222222, 32'h11111111},
         32'h1234, 32'h99, 1'b1, 1'b0);
    idle();
    latency("latency_bypass");
    chk("bypass_data", m_tdata, {32'hffffffff, 32'h80000001, 32'h22222222, 32'h11111111});
    chk("bypass_strb", m_tstrb, 16'hffff);
    drain("drain_bypass");

    // 64 back-to-back beats at full rate.
    for (int i = 0; i < 64; i++) begin
      send({$urandom, $urandom, $urandom, $urandom}, $urandom, $urandom, 1'b0, i == 63);
    end
    idle();
    drain("drain_burst64");

    // tlast on beats 3 and 7 of 8, bypass toggling.
    pat = {32'hdeadbeef, 32'h0badf00d, 32'h13579bdf, 32'h2468ace0};
    for (int i = 1; i <= 8; i++) begin
      send(pat ^ W'(i), 32'(i * 7), 32'(i * 3), 1'(i % 2), (i == 3) || (i == 7));
    end
    idle();
    drain("drain_tlast");

    // Random downstream backpressure with occasional input gaps.
    rnd_en = 1'b1;
    for (int i = 0; i < 200; i++) begin
      send({$urandom, $urandom, $urandom, $urandom}, $urandom, $urandom,
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) begin
        idle(); @(posedge clk); #1;
      end
    end
    idle();
    drain("drain_backpressure");
    rnd_en = 1'b0;
    m_tready = 1'b1;
    @(posedge clk); #1;

    // Asynchronous reset with one beat at the output and five in flight.
    send(32'(32'hA5A5), 32'd1, 32'd2, 1'b0, 1'b0);
    idle();
    @(posedge clk); #1;
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) send({4{32'(i + 100)}}, 32'd5, 32'(i), 1'b0, 1'b0);
    idle();
    chk("pre_reset_tvalid", m_tvalid, 1);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("async_rst_tvalid", m_tvalid, 0);
    chk("async_rst_s_tready", s_tready, 0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    repeat (12) @(posedge clk);
    #1;
    chk("post_reset_idle", m_tvalid, 0);
    send({32'h01020304, 32'h05060708, 32'h090a0b0c, 32'h0d0e0f10}, 32'd77, 32'd88, 1'b0, 1'b1);
    idle();
    latency("latency_after_reset");
    drain("drain_after_reset");

    chk("final_queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
